// File: rtl/stdp_synapse.sv
// stdp_synapse: a single plastic synapse that feeds the current input of the
// downstream lif neuron. It keeps exponentially decaying pre- and
// post-synaptic spike traces and adjusts its weight with trace-based STDP:
// potentiation when the post neuron fires, depression when the pre neuron
// fires.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   pre_spike   presynaptic spike, one-cycle pulse per event
//   post_spike  postsynaptic spike (driven by the lif spike output)
//   learn_en    1 = STDP (and optional decay) weight updates enabled
//   w_load      load strobe for w_in, has priority over STDP
//   w_in        weight load value, clamped to [W_MIN, W_MAX]
//   weight      current synaptic weight
//   current     registered synaptic current: weight on the cycle after pre_spike
//   pre_trace   presynaptic trace
//   post_trace  postsynaptic trace
//   w_changed   one-cycle pulse in the cycle the weight register took a new value
//
// Optional feature (macro STDP_WEIGHT_DECAY_EN): an idle counter that slowly
// decays the weight by 1 every DECAY_PERIOD cycles that have no spike and no
// load. Without the macro the weight changes only through STDP or a load.

module stdp_synapse #(
  parameter int W_INIT       = 64,
  parameter int W_MAX        = 127,
  parameter int W_MIN        = 0,
  parameter int TRACE_INC    = 128,
  parameter int TAU_SHIFT    = 3,
  parameter int A_POS_SHIFT  = 4,
  parameter int A_NEG_SHIFT  = 5,
  parameter int DECAY_PERIOD = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  input  logic       w_load,
  input  logic [7:0] w_in,
  output logic [7:0] weight,
  output logic [7:0] current,
  output logic [7:0] pre_trace,
  output logic [7:0] post_trace,
  output logic       w_changed
);

  localparam logic [7:0]        W_INIT_U = 8'(W_INIT);
  localparam logic [7:0]        W_MAX_U  = 8'(W_MAX);
  localparam logic [7:0]        W_MIN_U  = 8'(W_MIN);
  localparam logic signed [9:0] W_MAX_S  = 10'(W_MAX);
  localparam logic signed [9:0] W_MIN_S  = 10'(W_MIN);
  localparam logic [8:0]        INC_9    = 9'(TRACE_INC);

  // One trace step: subtract x >> TAU_SHIFT, forcing a decrement of at least
  // 1 so small traces actually reach zero, then add the spike increment with
  // saturation at 255 (sum formed 9 bits wide so the carry shows overflow).
  function automatic logic [7:0] trace_step(input logic [7:0] x, input logic spike);
    logic [7:0] d;
    logic [8:0] s;
    d = x >> TAU_SHIFT;
    if (d == 8'd0 && x != 8'd0) d = 8'd1;
    s = {1'b0, x - d} + (spike ? INC_9 : 9'd0);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [7:0]        pre_trace_next;
  logic [7:0]        post_trace_next;
  logic signed [9:0] ltp;
  logic signed [9:0] ltd;
  logic signed [9:0] w_sum;
  logic [7:0]        stdp_weight;
  logic [7:0]        load_weight;
  logic [7:0]        weight_next;
  logic              decay_hit;

`ifdef STDP_WEIGHT_DECAY_EN
  logic [15:0] idle_cnt;
  logic        idle;

  // The idle counter only runs while nothing happens on the synapse, so a
  // decay step can never land in the same cycle as an STDP or load update.
  assign idle      = !pre_spike && !post_spike && !w_load;
  assign decay_hit = idle && (idle_cnt == 16'(DECAY_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= 16'd0;
    end else if (!idle || decay_hit) begin
      idle_cnt <= 16'd0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign decay_hit = 1'b0;
`endif

  // Trace updates run every cycle regardless of learn_en or w_load.
  always_comb begin
    pre_trace_next  = trace_step(pre_trace, pre_spike);
    post_trace_next = trace_step(post_trace, post_spike);
  end

  // STDP uses the registered traces from before this cycle's update. Both
  // terms apply together on coincident spikes; the 10-bit signed sum cannot
  // overflow for 8-bit operands, so clamping it is exact.
  always_comb begin
    ltp = post_spike ? $signed({2'b00, pre_trace >> A_POS_SHIFT}) : 10'sd0;
    ltd = pre_spike ? $signed({2'b00, post_trace >> A_NEG_SHIFT}) : 10'sd0;
    w_sum = $signed({2'b00, weight}) + ltp - ltd;
    if (w_sum > W_MAX_S) begin
      stdp_weight = W_MAX_U;
    end else if (w_sum < W_MIN_S) begin
      stdp_weight = W_MIN_U;
    end else begin
      stdp_weight = w_sum[7:0];
    end
  end

  always_comb begin
    if (w_in > W_MAX_U) begin
      load_weight = W_MAX_U;
    end else if (w_in < W_MIN_U) begin
      load_weight = W_MIN_U;
    end else begin
      load_weight = w_in;
    end
  end

  // Weight selection: load beats everything, then the idle decay step (which
  // by construction only fires with no spikes present), then STDP.
  always_comb begin
    weight_next = weight;
    if (w_load) begin
      weight_next = load_weight;
    end else if (decay_hit) begin
      if (learn_en && weight > W_MIN_U) weight_next = weight - 8'd1;
    end else if (learn_en) begin
      weight_next = stdp_weight;
    end
  end

  // current samples the weight as it was before this cycle's update, so a
  // pre spike drives lif with the pre-learning weight one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight     <= W_INIT_U;
      current    <= 8'd0;
      pre_trace  <= 8'd0;
      post_trace <= 8'd0;
      w_changed  <= 1'b0;
    end else begin
      weight     <= weight_next;
      current    <= pre_spike ? weight : 8'd0;
      pre_trace  <= pre_trace_next;
      post_trace <= post_trace_next;
      w_changed  <= (weight_next != weight);
    end
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// tb_stdp_synapse: directed self-checking bench for stdp_synapse. Inputs
// change just after a rising edge, outputs are checked 1 time unit after the
// next rising edge. Expected values are hand-derived from the trace and
// STDP arithmetic of the synapse.

module tb_stdp_synapse;

  logic       clk;
  logic       rst;
  logic       pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic       w_load;
  logic [7:0] w_in;
  logic [7:0] weight;
  logic [7:0] current;
  logic [7:0] pre_trace;
  logic [7:0] post_trace;
  logic       w_changed;

  int checks = 0;
  int errors = 0;

  stdp_synapse dut (
    .clk        (clk),
    .rst        (rst),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .learn_en   (learn_en),
    .w_load     (w_load),
    .w_in       (w_in),
    .weight     (weight),
    .current    (current),
    .pre_trace  (pre_trace),
    .post_trace (post_trace),
    .w_changed  (w_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic p, input logic q, input logic ld,
                               input logic [7:0] wv);
    pre_spike  = p;
    post_spike = q;
    w_load     = ld;
    w_in       = wv;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
    learn_en   = 1'b1;
    w_load     = 1'b0;
    w_in       = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_weight", weight, 8'd64);
    checkOutput("reset_pre_trace", pre_trace, 8'd0);
    checkOutput("reset_post_trace", post_trace, 8'd0);
    checkOutput("reset_current", current, 8'd0);
    checkOutput("reset_w_changed", {7'd0, w_changed}, 8'd0);
    rst = 1'b0;

    // LTP: pre at t, post at t+1
    $display("[TB] LTP pre then post");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("ltp_pre_trace_t1", pre_trace, 8'd128);
    checkOutput("ltp_current_t1", current, 8'd64);
    checkOutput("ltp_weight_t1", weight, 8'd64);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("ltp_weight_t2", weight, 8'd72);
    checkOutput("ltp_w_changed_t2", {7'd0, w_changed}, 8'd1);
    checkOutput("ltp_pre_trace_t2", pre_trace, 8'd112);
    checkOutput("ltp_post_trace_t2", post_trace, 8'd128);
    checkOutput("ltp_current_t2", current, 8'd0);
    idleCycles(1);
    checkOutput("ltp_w_changed_t3", {7'd0, w_changed}, 8'd0);

    // Delayed LTP: pre at t, post at t+3
    $display("[TB] delayed LTP");
    idleCycles(60);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd64);
    checkOutput("dltp_load_weight", weight, 8'd64);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("dltp_pre_trace_1", pre_trace, 8'd128);
    idleCycles(1);
    checkOutput("dltp_pre_trace_2", pre_trace, 8'd112);
    idleCycles(1);
    checkOutput("dltp_pre_trace_3", pre_trace, 8'd98);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("dltp_weight", weight, 8'd70);

    // LTD: post at t, pre at t+1
    $display("[TB] LTD post then pre");
    idleCycles(60);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd64);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("ltd_post_trace", post_trace, 8'd128);
    checkOutput("ltd_weight_hold", weight, 8'd64);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("ltd_weight", weight, 8'd60);
    checkOutput("ltd_current", current, 8'd64);
    checkOutput("ltd_w_changed", {7'd0, w_changed}, 8'd1);

    // Coincident pre and post with both traces at zero
    $display("[TB] coincidence");
    idleCycles(60);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd64);
    checkOutput("coin_load_w_changed", {7'd0, w_changed}, 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    checkOutput("coin_weight", weight, 8'd64);
    checkOutput("coin_w_changed", {7'd0, w_changed}, 8'd0);
    checkOutput("coin_pre_trace", pre_trace, 8'd128);
    checkOutput("coin_post_trace", post_trace, 8'd128);

    // Saturation: load clamp, then LTP at the upper clamp
    $display("[TB] saturation");
    idleCycles(60);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd200);
    checkOutput("sat_load_clamp", weight, 8'd127);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("sat_pre_trace", pre_trace, 8'd128);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("sat_weight_clamped", weight, 8'd127);
    checkOutput("sat_w_changed", {7'd0, w_changed}, 8'd0);

    // Three consecutive pre spikes saturate the trace
    idleCycles(60);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("burst_trace_1", pre_trace, 8'd128);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("burst_trace_2", pre_trace, 8'd240);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("burst_trace_3", pre_trace, 8'd255);

    // Trace tail: 128 reaches 7 after 25 idle cycles, then steps by 1 to 0
    $display("[TB] trace tail");
    idleCycles(60);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    idleCycles(25);
    checkOutput("tail_7", pre_trace, 8'd7);
    idleCycles(1);
    checkOutput("tail_6", pre_trace, 8'd6);
    idleCycles(1);
    checkOutput("tail_5", pre_trace, 8'd5);
    idleCycles(4);
    checkOutput("tail_1", pre_trace, 8'd1);
    idleCycles(1);
    checkOutput("tail_0", pre_trace, 8'd0);
    idleCycles(1);
    checkOutput("tail_stays_0", pre_trace, 8'd0);

    // learn_en = 0: weight held, traces still evolve
    $display("[TB] learning disabled");
    idleCycles(60);
    learn_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd64);
    checkOutput("nolearn_load", weight, 8'd64);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("nolearn_weight", weight, 8'd64);
    checkOutput("nolearn_w_changed", {7'd0, w_changed}, 8'd0);
    checkOutput("nolearn_pre_trace", pre_trace, 8'd112);
    checkOutput("nolearn_post_trace", post_trace, 8'd128);
    learn_en = 1'b1;

    // Idle weight decay: 256 idle cycles after a load
    $display("[TB] idle decay");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd64);
    idleCycles(255);
    checkOutput("decay_before", weight, 8'd64);
    idleCycles(1);
`ifdef STDP_WEIGHT_DECAY_EN
    checkOutput("decay_weight", weight, 8'd63);
    checkOutput("decay_w_changed", {7'd0, w_changed}, 8'd1);
`else
    checkOutput("decay_weight", weight, 8'd64);
    checkOutput("decay_w_changed", {7'd0, w_changed}, 8'd0);
`endif

    // Mid-run asynchronous reset with weight = 90
    $display("[TB] mid-run reset");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd90);
    checkOutput("pre_rst_weight", weight, 8'd90);
    checkOutput("pre_rst_w_changed", {7'd0, w_changed}, 8'd1);
    checkOutput("pre_rst_pre_trace", pre_trace, 8'd128);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("pre_rst_current", current, 8'd90);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_weight", weight, 8'd64);
    checkOutput("rst_pre_trace", pre_trace, 8'd0);
    checkOutput("rst_post_trace", post_trace, 8'd0);
    checkOutput("rst_current", current, 8'd0);
    checkOutput("rst_w_changed", {7'd0, w_changed}, 8'd0);
    #10;
    rst = 1'b0;
    pre_spike = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
